multi_pipe_fifo_bridge: RTL and testbench
=========================================

// Module: multi_pipe_fifo_bridge
// PURPOSE
//  NCH-channel buffer between user data producers and one okPipeOut endpoint.
//  Each channel has its own FIFO, a programmable-threshold host interrupt, a
//  last-write capture register, and sticky overflow/underflow flags.
//  The host selects the channel to drain through a WireIn and bulk-reads it over the pipe.
//  Generalises the single half-full FIFO readout path.
// PARAMETERS
//  NCH        4       number of channels (1..16)
//  DATA_W     32      word width, matches the pipe endpoint
//  AW         10      FIFO address width; depth = 2**AW words per channel
//  SEL_W      2       width of sel; must be >= clog2(NCH), min 1
//  UFLOW_WORD 32'hDEAD_BEEF  word returned on read of an empty channel
// PORTS
//  clk           in   1            single system clock (okClk domain)
//  rst           in   1            synchronous active-high reset, whole block
//  rst_fifo      in   NCH          per-channel synchronous flush (TriggerIn bits)
//  wr_en         in   NCH          per-channel write strobe
//  wr_data       in   NCH*DATA_W   channel c data on [c*DATA_W +: DATA_W]
//  threshold     in   AW+1         interrupt level in words; 0 disables interrupts
//  sel           in   SEL_W        channel drained by ep_read; values >= NCH select none
//  ep_read       in   1            pipe read strobe from okPipeOut
//  dout          out  DATA_W       pipe data; valid the cycle after ep_read
//  count_sel     out  AW+1         current word count of the selected channel
//  last_write    out  DATA_W       last word accepted into the selected channel
//  hostinterrupt out  NCH          per-channel count >= threshold (threshold != 0)
//  full          out  NCH          per-channel count == 2**AW
//  overflow      out  NCH          sticky: write attempted while full
//  underflow     out  NCH          sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst): all counts and pointers 0, dout=0, last_write regs=0,
//    hostinterrupt/full/overflow/underflow=0. RAM contents are not cleared.
//  - rst_fifo[c]: clears count, pointers, last_write, overflow and underflow
//    of channel c only. Any same-cycle write or read on c is ignored.
//  - Write: when wr_en[c] and not full[c], store the word at wptr, increment
//    wptr (mod 2**AW), and load last_write[c]. When full[c], drop the word
//    and set overflow[c]. Count and pointers are unchanged.
//  - Read: ep_read applies to channel sel in the same cycle. If that channel
//    is non-empty, dout <= mem[rptr] on the next edge and rptr increments.
//    If it is empty, dout <= UFLOW_WORD, underflow is set, and pointers hold.
//    If sel >= NCH, dout <= UFLOW_WORD and no flags change.
//    dout holds its value when ep_read is low.
//  - Simultaneous write and read on the same channel, both accepted:
//    count unchanged. A write to an empty channel is readable the following
//    cycle, not the same cycle.
//  - Count width is AW+1. Count 2**AW means full. Pointers wrap silently.
//  - hostinterrupt[c], full[c], count_sel and last_write are registered from
//    post-update count/state, so they lag the causing edge by one cycle.
//    count_sel/last_write follow a sel change after one cycle.
//  - Flags are sticky until rst or rst_fifo[c]. Reading does not clear them.
//  - A threshold change takes effect on the next registered update of
//    hostinterrupt. No hysteresis.
//  - Memory: one simple dual-port RAM per channel, with 1-cycle synchronous
//    read (block-RAM inferable). No combinational path from ep_read to dout.
// TESTING
//  1 Reset: assert rst 2 cycles -> all outputs 0, count_sel=0.
//  2 Fill ch1: NCH=4, AW=4, threshold=8, write 0x100..0x10F to ch1
//    -> hostinterrupt[1] after the 8th write; full[1] after the 16th.
//    A 17th write sets overflow[1]; last_write=0x10F.
//  3 Drain ch1: sel=1, 16 ep_read pulses -> dout sequence 0x100..0x10F, each
//    one cycle after its strobe. The 17th read gives 0xDEADBEEF and sets
//    underflow[1]. count_sel reaches 0.
//  4 Concurrent: ch2 holds 3 words; write and read ch2 in the same cycle for
//    20 cycles -> count stays 3, data remains in order, and the pointers wrap
//    without error.
//  5 Isolation: pulse rst_fifo[0] while ch0 and ch3 are both half full
//    -> ch0 count=0 and its flags clear; ch3 count and data are unchanged.
//  6 Reset mid-burst: assert rst during continuous ep_read on ch1
//    -> next cycle dout=0, all counts 0, and no spurious flags after release.

Source files
------------

// File: rtl/multi_pipe_fifo_bridge.sv
// Multi-channel FIFO bridge feeding one pipe-out endpoint: per-channel block-RAM
// FIFOs with threshold interrupts, last-write capture and sticky error flags.
module multi_pipe_fifo_bridge #(
  parameter int NCH = 4,
  parameter int DATA_W = 32,
  parameter int AW = 10,
  parameter int SEL_W = 2,
  parameter logic [DATA_W-1:0] UFLOW_WORD = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        rst_fifo,
  input  logic [NCH-1:0]        wr_en,
  input  logic [NCH*DATA_W-1:0] wr_data,
  input  logic [AW:0]           threshold,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  ep_read,
  output logic [DATA_W-1:0]     dout,
  output logic [AW:0]           count_sel,
  output logic [DATA_W-1:0]     last_write,
  output logic [NCH-1:0]        hostinterrupt,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        overflow,
  output logic [NCH-1:0]        underflow
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_DATA,
    SRC_UFLOW
  } dout_src_e;

  logic [NCH-1:0]    sel_hit;
  logic              sel_valid;
  logic              sel_flush;
  logic [AW:0]       cnt_arr [NCH];
  logic [DATA_W-1:0] lw_arr  [NCH];
  logic [DATA_W-1:0] rdq_arr [NCH];
  logic [AW:0]       cnt_mux;
  logic [DATA_W-1:0] lw_mux;
  dout_src_e         dout_src;
  logic [NCH-1:0]    dout_oh;

  always_comb begin
    sel_hit = '0;
    for (int c = 0; c < NCH; c++) begin
      sel_hit[c] = (sel == SEL_W'(c));
    end
  end

  assign sel_valid = |sel_hit;
  assign sel_flush = |(sel_hit & rst_fifo);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       cnt;
    logic [DATA_W-1:0] lw;
    logic [DATA_W-1:0] rdq;
    logic [DATA_W-1:0] wdata;
    logic              hi_q;
    logic              full_q;
    logic              ovf_q;
    logic              udf_q;
    logic              is_full;
    logic              is_empty;
    logic              live;
    logic              rd_req;
    logic              wr_acc;
    logic              wr_drop;
    logic              rd_acc;
    logic              rd_uf;

    assign wdata    = wr_data[c*DATA_W +: DATA_W];
    assign is_full  = (cnt == FULL_CNT);
    assign is_empty = (cnt == '0);
    // A flush or global reset swallows any write/read on this channel that cycle.
    assign live     = ~rst & ~rst_fifo[c];
    assign rd_req   = live & ep_read & sel_hit[c];
    assign wr_acc   = live & wr_en[c] & ~is_full;
    assign wr_drop  = live & wr_en[c] & is_full;
    assign rd_acc   = rd_req & ~is_empty;
    assign rd_uf    = rd_req & is_empty;

    // Storage and its registered read port carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
      if (wr_acc) begin
        mem[wptr] <= wdata;
      end
      if (rd_acc) begin
        rdq <= mem[rptr];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr   <= '0;
        rptr   <= '0;
        cnt    <= '0;
        lw     <= '0;
        hi_q   <= 1'b0;
        full_q <= 1'b0;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
      end else begin
        hi_q   <= (threshold != '0) && (cnt >= threshold);
        full_q <= is_full;
        if (rst_fifo[c]) begin
          wptr  <= '0;
          rptr  <= '0;
          cnt   <= '0;
          lw    <= '0;
          ovf_q <= 1'b0;
          udf_q <= 1'b0;
        end else begin
          if (wr_acc) begin
            wptr <= wptr + PTR_ONE;
            lw   <= wdata;
          end
          if (rd_acc) begin
            rptr <= rptr + PTR_ONE;
          end
          if (wr_drop) begin
            ovf_q <= 1'b1;
          end
          if (rd_uf) begin
            udf_q <= 1'b1;
          end
          case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
          endcase
        end
      end
    end

    assign cnt_arr[c]       = cnt;
    assign lw_arr[c]        = lw;
    assign rdq_arr[c]       = rdq;
    assign hostinterrupt[c] = hi_q;
    assign full[c]          = full_q;
    assign overflow[c]      = ovf_q;
    assign underflow[c]     = udf_q;
  end

  always_comb begin
    cnt_mux = '0;
    lw_mux  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_hit[c]) begin
        cnt_mux = cnt_arr[c];
        lw_mux  = lw_arr[c];
      end
    end
  end

  // dout is steered by registered state only, so ep_read never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_sel  <= '0;
      last_write <= '0;
      dout_src   <= SRC_ZERO;
      dout_oh    <= '0;
    end else begin
      count_sel  <= cnt_mux;
      last_write <= lw_mux;
      if (ep_read) begin
        if (!sel_valid) begin
          dout_src <= SRC_UFLOW;
        end else if (!sel_flush) begin
          if (cnt_mux == '0) begin
            dout_src <= SRC_UFLOW;
          end else begin
            dout_src <= SRC_DATA;
            dout_oh  <= sel_hit;
          end
        end
      end
    end
  end

  always_comb begin
    dout = '0;
    case (dout_src)
      SRC_DATA: begin
        for (int c = 0; c < NCH; c++) begin
          if (dout_oh[c]) begin
            dout = rdq_arr[c];
          end
        end
      end
      SRC_UFLOW: dout = UFLOW_WORD;
      default:   dout = '0;
    endcase
  end

endmodule

// File: tb/tb_multi_pipe_fifo_bridge.sv
// Self-checking bench for multi_pipe_fifo_bridge: hand-derived vector table, directed
// corner sequences, and random traffic compared against a queue-based reference model.
module tb_multi_pipe_fifo_bridge;

  localparam int NCH = 4;
  localparam int AW = 4;
  localparam int SEL_W = 3;
  localparam int DEPTH = 16;
  localparam logic [31:0] UF = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   rst_fifo;
  logic [3:0]   wr_en;
  logic [127:0] wr_data;
  logic [4:0]   threshold;
  logic [2:0]   sel;
  logic         ep_read;
  logic [31:0]  dout;
  logic [4:0]   count_sel;
  logic [31:0]  last_write;
  logic [3:0]   hostinterrupt;
  logic [3:0]   full;
  logic [3:0]   overflow;
  logic [3:0]   underflow;

  always #5 clk = ~clk;

  multi_pipe_fifo_bridge #(
    .NCH(NCH), .DATA_W(32), .AW(AW), .SEL_W(SEL_W), .UFLOW_WORD(UF)
  ) dut (
    .clk(clk), .rst(rst), .rst_fifo(rst_fifo), .wr_en(wr_en), .wr_data(wr_data),
    .threshold(threshold), .sel(sel), .ep_read(ep_read), .dout(dout),
    .count_sel(count_sel), .last_write(last_write), .hostinterrupt(hostinterrupt),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  // Reference model: each channel is a plain word queue plus flag bits.
  logic [31:0] mq [NCH][$];
  logic [31:0] mlw [NCH];
  logic [3:0]  movf, mudf, mhi, mfull;
  logic [31:0] mdout, mlwsel;
  logic [4:0]  mcsel;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        r;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [2:0]  s;
    logic        er;
    logic [31:0] e_dout;
    logic [4:0]  e_cnt;
    logic [31:0] e_lw;
    logic [3:0]  e_hi;
    logic [3:0]  e_full;
    logic [3:0]  e_ovf;
    logic [3:0]  e_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic modelEdge();
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        mlw[c] = '0;
      end
      movf = '0; mudf = '0; mhi = '0; mfull = '0;
      mdout = '0; mcsel = '0; mlwsel = '0;
    end else begin
      int s;
      s = int'(sel);
      // Lagged outputs reflect the state left by the previous edge.
      for (int c = 0; c < NCH; c++) begin
        mhi[c]   = (threshold != 0) && (mq[c].size() >= int'(threshold));
        mfull[c] = (mq[c].size() == DEPTH);
      end
      if (s < NCH) begin
        mcsel  = 5'(mq[s].size());
        mlwsel = mlw[s];
      end else begin
        mcsel  = '0;
        mlwsel = '0;
      end
      if (ep_read && s >= NCH) mdout = UF;
      for (int c = 0; c < NCH; c++) begin
        if (rst_fifo[c]) begin
          mq[c].delete();
          mlw[c]  = '0;
          movf[c] = 1'b0;
          mudf[c] = 1'b0;
        end else begin
          int pre;
          pre = mq[c].size();
          if (ep_read && s == c) begin
            if (pre > 0) mdout = mq[c].pop_front();
            else begin
              mdout   = UF;
              mudf[c] = 1'b1;
            end
          end
          if (wr_en[c]) begin
            if (pre == DEPTH) movf[c] = 1'b1;
            else begin
              mq[c].push_back(wr_data[c*32 +: 32]);
              mlw[c] = wr_data[c*32 +: 32];
            end
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("model_dout", dout, mdout);
    checkValue("model_count_sel", 32'(count_sel), 32'(mcsel));
    checkValue("model_last_write", last_write, mlwsel);
    checkValue("model_hostinterrupt", 32'(hostinterrupt), 32'(mhi));
    checkValue("model_full", 32'(full), 32'(mfull));
    checkValue("model_overflow", 32'(overflow), 32'(movf));
    checkValue("model_underflow", 32'(underflow), 32'(mudf));
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rf, input logic [3:0] we,
                               input logic [127:0] wd, input logic [2:0] s,
                               input logic er, input logic [4:0] th);
    rst = r; rst_fifo = rf; wr_en = we; wr_data = wd;
    sel = s; ep_read = er; threshold = th;
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput();
  endtask

  task automatic addVec(input logic r, input logic [3:0] we, input logic [31:0] wd,
                        input logic [2:0] s, input logic er, input logic [31:0] e_dout,
                        input int e_cnt, input logic [31:0] e_lw, input logic [3:0] e_hi,
                        input logic [3:0] e_full, input logic [3:0] e_ovf, input logic [3:0] e_udf);
    vec_t v;
    v.r = r; v.we = we; v.wd = wd; v.s = s; v.er = er;
    v.e_dout = e_dout; v.e_cnt = 5'(e_cnt); v.e_lw = e_lw; v.e_hi = e_hi;
    v.e_full = e_full; v.e_ovf = e_ovf; v.e_udf = e_udf;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; rst_fifo = '0; wr_en = '0; wr_data = '0;
    threshold = 5'd8; sel = 3'd1; ep_read = 1'b0;

    // Reset, fill ch1 to overflow, then drain it to underflow (threshold 8, depth 16).
    addVec(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 16; k++) begin
      addVec(0, 4'b0010, 32'h100 + 32'(k), 1, 0, 0, (k < 16) ? k : 16,
             (k == 0) ? 32'h0 : 32'h100 + 32'(k - 1),
             (k >= 8) ? 4'b0010 : 4'b0000, (k >= 16) ? 4'b0010 : 4'b0000,
             (k == 16) ? 4'b0010 : 4'b0000, 4'b0000);
    end
    addVec(0, 4'b0000, 0, 1, 0, 0, 16, 32'h10F, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    for (int j = 0; j <= 16; j++) begin
      addVec(0, 4'b0000, 0, 1, 1, (j < 16) ? 32'h100 + 32'(j) : UF, 16 - j, 32'h10F,
             (j <= 8) ? 4'b0010 : 4'b0000, (j == 0) ? 4'b0010 : 4'b0000,
             4'b0010, (j == 16) ? 4'b0010 : 4'b0000);
    end
    addVec(0, 4'b0000, 0, 1, 0, UF, 0, 32'h10F, 0, 0, 4'b0010, 4'b0010);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, 4'b0000, vecs[i].we, {4{vecs[i].wd}}, vecs[i].s, vecs[i].er, 5'd8);
      checkValue($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
      checkValue($sformatf("vec%0d_count_sel", i), 32'(count_sel), 32'(vecs[i].e_cnt));
      checkValue($sformatf("vec%0d_last_write", i), last_write, vecs[i].e_lw);
      checkValue($sformatf("vec%0d_hostinterrupt", i), 32'(hostinterrupt), 32'(vecs[i].e_hi));
      checkValue($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      checkValue($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      checkValue($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].e_udf));
    end

    // Concurrent write+read on ch2 holding 3 words; pointers wrap past depth.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'b0100, {4{32'h200 + 32'(i)}}, 2, 0, 8);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 4'b0100, {4{32'h203 + 32'(i)}}, 2, 1, 8);
      checkValue("conc_dout", dout, 32'h200 + 32'(i));
      checkValue("conc_count_sel", 32'(count_sel), 32'd3);
    end
    applyStimulus(0, 0, 0, 0, 2, 0, 8);
    checkValue("conc_count_final", 32'(count_sel), 32'd3);

    // Flush of ch0 must leave the half-full ch3 untouched.
    applyStimulus(0, 0, 0, 0, 0, 1, 8);
    checkValue("iso_udf_set", 32'(underflow[0]), 32'd1);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 4'b1001, {32'hD000 + 32'(i), 64'h0, 32'hA000 + 32'(i)}, 0, 0, 8);
    applyStimulus(0, 4'b0001, 0, 0, 0, 0, 8);
    checkValue("iso_udf_clr", 32'(underflow[0]), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 8);
    checkValue("iso_ch0_count", 32'(count_sel), 32'd0);
    checkValue("iso_ch0_hi", 32'(hostinterrupt[0]), 32'd0);
    applyStimulus(0, 0, 0, 0, 3, 0, 8);
    checkValue("iso_ch3_count", 32'(count_sel), 32'd8);
    checkValue("iso_ch3_hi", 32'(hostinterrupt[3]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 3, 1, 8);
      checkValue("iso_ch3_dout", dout, 32'hD000 + 32'(i));
    end

    // Global reset in the middle of a read burst.
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 4'b0010, {4{32'h300 + 32'(i)}}, 1, 0, 8);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 8);
      checkValue("burst_dout", dout, 32'h300 + 32'(i));
    end
    applyStimulus(1, 0, 0, 0, 1, 1, 8);
    checkValue("burst_rst_dout", dout, 32'h0);
    checkValue("burst_rst_udf", 32'(underflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 8);
      checkValue("burst_post_count", 32'(count_sel), 32'd0);
      checkValue("burst_post_flags", 32'({overflow, underflow, full, hostinterrupt}), 32'd0);
    end

    // Random traffic against the reference model.
    begin
      logic [4:0] th;
      int wr_bias;
      th = 5'd8;
      wr_bias = 60;
      for (int n = 0; n < 1200; n++) begin
        logic [3:0] we, rf;
        logic [2:0] s;
        if (n % 64 == 0) th = 5'($urandom_range(0, 16));
        if (n % 50 == 0) wr_bias = int'($urandom_range(10, 90));
        for (int c = 0; c < NCH; c++) begin
          we[c] = ($urandom_range(0, 99) < wr_bias);
          rf[c] = ($urandom_range(0, 79) == 0);
        end
        s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
        applyStimulus($urandom_range(0, 299) == 0, rf, we,
                      {$urandom, $urandom, $urandom, $urandom}, s,
                      $urandom_range(0, 1) == 1, th);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
